// File: rtl/bank_round_robin.sv
// One shared-memory bank slice: a 256x8 byte store plus a
// 16-way round-robin selector for the core being served.
module bank_round_robin #(
  parameter int N_CORES = 16,
  parameter int CNT_W   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CORES-1:0] core_val,
  input  logic              core_serv,
  output logic [CNT_W-1:0]  core_cnt,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              finish
);

  logic [CNT_W-1:0]  core_cnt_q, core_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              finish_q, finish_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             accept;
  logic             mem_we;
  logic [CNT_W-1:0] idx;
  logic             found;

  // Search starts one past the current core so it is checked last.
  always_comb begin
    core_cnt_d = core_cnt_q;
    found      = 1'b0;
    idx        = '0;
    if (!core_serv) begin
      for (int i = 1; i <= N_CORES; i++) begin
        idx = core_cnt_q + CNT_W'(i);
        if (!found && core_val[idx]) begin
          core_cnt_d = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // A finish cycle blocks acceptance, so accesses are 2 cycles apart.
  always_comb begin
    accept     = (read | write) & ~finish_q;
    mem_we     = accept & write;
    finish_d   = accept;
    data_out_d = data_out_q;
    if (accept && read && !write)
      data_out_d = mem_q[addr_in];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      core_cnt_q <= '0;
      data_out_q <= '0;
      finish_q   <= 1'b0;
    end else begin
      core_cnt_q <= core_cnt_d;
      data_out_q <= data_out_d;
      finish_q   <= finish_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_in] <= data_in;
    end
  end

  assign core_cnt = core_cnt_q;
  assign data_out = data_out_q;
  assign finish   = finish_q;

endmodule

// File: tb/tb_bank_round_robin.sv
// Bench for bank_round_robin: directed pinned cases, then
// random traffic against a behavioural model.
module tb_bank_round_robin;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] core_val;
  logic        core_serv;
  logic [3:0]  core_cnt;
  logic        read, write;
  logic [7:0]  addr_in, data_in;
  logic [7:0]  data_out;
  logic        finish;

  int errs = 0;
  int checks = 0;

  int m_cnt;
  int m_dout;
  int m_fin;
  int m_mem [256];
  int c;

  bit       pin_cnt_en, pin_fin_en, pin_dout_en;
  int       pin_cnt, pin_fin, pin_dout;

  bank_round_robin dut (
    .clock    (clock),
    .reset    (reset),
    .core_val (core_val),
    .core_serv(core_serv),
    .core_cnt (core_cnt),
    .read     (read),
    .write    (write),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out),
    .finish   (finish)
  );

  always #5 clock = ~clock;

  // Reference model: one access per request, then a blocked cycle.
  always @(posedge clock) begin
    if (reset) begin
      m_cnt  = 0;
      m_dout = 0;
      m_fin  = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      if (!core_serv && core_val != 16'h0) begin
        for (int k = 1; k <= 16; k++) begin
          c = (m_cnt + k) % 16;
          if (core_val[c]) begin
            m_cnt = c;
            break;
          end
        end
      end
      if ((read || write) && m_fin == 0) begin
        if (write) m_mem[addr_in] = int'(data_in);
        else m_dout = m_mem[addr_in];
        m_fin = 1;
      end else begin
        m_fin = 0;
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clock) begin
    check("core_cnt", int'(core_cnt), m_cnt);
    check("finish", int'(finish), m_fin);
    check("data_out", int'(data_out), m_dout);
    if (pin_cnt_en) begin
      check("pin_cnt_dut", int'(core_cnt), pin_cnt);
      check("pin_cnt_model", m_cnt, pin_cnt);
    end
    if (pin_fin_en) begin
      check("pin_fin_dut", int'(finish), pin_fin);
      check("pin_fin_model", m_fin, pin_fin);
    end
    if (pin_dout_en) begin
      check("pin_dout_dut", int'(data_out), pin_dout);
      check("pin_dout_model", m_dout, pin_dout);
    end
  end

  task automatic cyc(input logic rs, input logic [15:0] v,
                     input logic sv, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    #1;
    pin_cnt_en  = 1'b0;
    pin_fin_en  = 1'b0;
    pin_dout_en = 1'b0;
    reset     = rs;
    core_val  = v;
    core_serv = sv;
    read      = rd;
    write     = wr;
    addr_in   = a;
    data_in   = d;
  endtask

  task automatic pc(input int v);
    pin_cnt_en = 1'b1;
    pin_cnt    = v;
  endtask

  task automatic pf(input int v);
    pin_fin_en = 1'b1;
    pin_fin    = v;
  endtask

  task automatic pd(input int v);
    pin_dout_en = 1'b1;
    pin_dout    = v;
  endtask

  int fpat [6] = '{1, 0, 1, 0, 1, 0};
  int rr   [4] = '{2, 15, 0, 2};

  initial begin
    reset = 1'b1; core_val = '0; core_serv = 1'b0;
    read = 1'b0; write = 1'b0; addr_in = '0; data_in = '0;
    // Reset dominates concurrent writes and selector requests
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 8'h55, 8'hC3);
      pc(0); pf(0); pd(0);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
    pf(1); pd(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0);
    // Write then read back
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5);
    pf(1); pd(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00);
    pf(1); pd(8'hA5);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0);
    // Held read completes every second cycle
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h77);
    pf(1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      pf(fpat[i]); pd(8'h77);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0); pd(8'h77); pc(0);
    // Round robin across cores 0, 2, 15
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h8005, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      pc(rr[i]);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 16'h8005, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      pc(2);
    end
    // Wrap and idle hold
    cyc(1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pc(15);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pc(15);
    cyc(1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pc(0);
    cyc(1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pc(0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pc(0);
    // Read and write together: write wins
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h3E);
    pf(1); pd(8'h77);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0); pd(8'h77);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    pf(1); pd(8'h3E);
    // Access in flight dropped by reset
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h99);
    pf(1);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    pf(0); pd(0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    pf(1); pd(0);
    // Random traffic on a narrow address window
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          16'($urandom) & 16'($urandom),
          1'($urandom_range(0, 2) == 0),
          1'($urandom), 1'($urandom_range(0, 2) == 0),
          8'($urandom_range(0, 15)), 8'($urandom));
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
